// File: rtl/stream_mux_arb.sv
// stream_mux_arb: merges 2^SELECT_WIDTH valid/ready streams onto one registered output.
// Ports: clk/rst_n; in_datas/in_valid/in_last/in_ready per channel; select (external grant);
//        out_data/out_valid/out_last/out_channel/out_ready for the merged stream; locked status.
//
// Purpose: stream mux with external-select or round-robin grant and per-packet channel lock.
// Latency: 1 cycle from accepted input beat to out_valid.
// Backpressure: in_ready only to the granted channel while the output register can load.
module stream_mux_arb #(
  parameter int DATA_WIDTH   = 8,
  parameter int SELECT_WIDTH = 2,
  parameter int ARB_MODE     = 0
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [DATA_WIDTH*(1<<SELECT_WIDTH)-1:0]  in_datas,
  input  logic [(1<<SELECT_WIDTH)-1:0]             in_valid,
  input  logic [(1<<SELECT_WIDTH)-1:0]             in_last,
  output logic [(1<<SELECT_WIDTH)-1:0]             in_ready,
  input  logic [SELECT_WIDTH-1:0]                  select,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic                                     out_valid,
  output logic                                     out_last,
  output logic [SELECT_WIDTH-1:0]                  out_channel,
  input  logic                                     out_ready,
  output logic                                     locked
);

  localparam int CHANNELS = 1 << SELECT_WIDTH;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state;
  logic [SELECT_WIDTH-1:0] lock_chan;
  logic [SELECT_WIDTH-1:0] rr_ptr;

  logic                    load_en;
  logic [SELECT_WIDTH-1:0] grant;
  logic                    grant_vld;
  logic [SELECT_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_last;
  logic                    xfer;

  // Single output register: loads whenever empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;

  always_comb begin
    grant     = lock_chan;
    grant_vld = 1'b0;
    idx       = '0;
    if (locked) begin
      grant     = lock_chan;
      grant_vld = 1'b1;
    end else if (ARB_MODE == 0) begin
      grant     = select;
      grant_vld = 1'b1;
    end else begin
      // Scan rr_ptr+1 .. rr_ptr+CHANNELS; the last offset truncates to 0 so the
      // pointer's own channel is checked last. Wrap is plain SELECT_WIDTH overflow.
      for (int i = 1; i <= CHANNELS; i++) begin
        idx = rr_ptr + SELECT_WIDTH'(i);
        if (!grant_vld && in_valid[idx]) begin
          grant     = idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant == SELECT_WIDTH'(k)) begin
        in_ready[k] = load_en && grant_vld;
        sel_data    = in_datas[k*DATA_WIDTH +: DATA_WIDTH];
        sel_last    = in_last[k];
      end
    end
  end

  assign xfer = load_en && grant_vld && in_valid[grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      locked      <= 1'b0;
      lock_chan   <= '0;
      rr_ptr      <= '1;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_channel <= '0;
    end else if (xfer) begin
      out_data    <= sel_data;
      out_last    <= sel_last;
      out_channel <= grant;
      out_valid   <= 1'b1;
      case (state)
        IDLE: begin
          // Single-beat packets never enter LOCKED.
          if (!sel_last) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            lock_chan <= grant;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
      // Pointer moves per packet so multi-beat packets do not shift fairness.
      if (sel_last) begin
        rr_ptr <= grant;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed checks of stream_mux_arb in external-select and round-robin modes.
// Ports: none (top-level bench); one instance per ARB_MODE sharing the same input stimulus.
module tb_stream_mux_arb;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_datas;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [1:0]  select;
  logic        out_ready;

  logic [3:0]  e_ready, r_ready;
  logic [7:0]  e_data, r_data;
  logic        e_valid, r_valid, e_last, r_last, e_locked, r_locked;
  logic [1:0]  e_chan, r_chan;

  int total;
  int bad;

  stream_mux_arb #(.DATA_WIDTH(8), .SELECT_WIDTH(2), .ARB_MODE(0)) u_ext (
    .clk(clk), .rst_n(rst_n), .in_datas(in_datas), .in_valid(in_valid),
    .in_last(in_last), .in_ready(e_ready), .select(select), .out_data(e_data),
    .out_valid(e_valid), .out_last(e_last), .out_channel(e_chan),
    .out_ready(out_ready), .locked(e_locked)
  );

  stream_mux_arb #(.DATA_WIDTH(8), .SELECT_WIDTH(2), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_datas(in_datas), .in_valid(in_valid),
    .in_last(in_last), .in_ready(r_ready), .select(select), .out_data(r_data),
    .out_valid(r_valid), .out_last(r_last), .out_channel(r_chan),
    .out_ready(out_ready), .locked(r_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; registered outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [7:0] v);
    in_datas[k*8 +: 8] = v;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_datas  = '0;
    in_valid  = '0;
    in_last   = '0;
    select    = 2'd2;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_e_valid", e_valid, 0);
    chk("rst_e_locked", e_locked, 0);
    chk("rst_e_data", e_data, 0);
    chk("rst_e_chan", e_chan, 0);
    chk("rst_e_ready", e_ready, 4'b0100);
    chk("rst_r_ready", r_ready, 4'b0000);
    chk("rst_r_valid", r_valid, 0);

    // MODE 0 single beats on channel 2.
    in_valid = 4'b0100;
    in_last  = 4'b1111;
    set_data(2, 8'hA5);
    #1;
    chk("m0_ready", e_ready, 4'b0100);
    step();
    chk("m0_data", e_data, 8'hA5);
    chk("m0_chan", e_chan, 2);
    chk("m0_last", e_last, 1);
    chk("m0_valid", e_valid, 1);
    set_data(2, 8'h5A);
    step();
    chk("m0_data2", e_data, 8'h5A);

    // Backpressure: hold 0x3C for 3 stalled cycles.
    set_data(2, 8'h3C);
    step();
    chk("bp_load", e_data, 8'h3C);
    out_ready = 1'b0;
    set_data(2, 8'hC3);
    #1;
    chk("bp_ready0", e_ready, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", e_data, 8'h3C);
      chk("bp_hold_valid", e_valid, 1);
      chk("bp_hold_ready", e_ready, 4'b0000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready1", e_ready, 4'b0100);
    step();
    chk("bp_next", e_data, 8'hC3);
    chk("bp_next_valid", e_valid, 1);
    in_valid = 4'b0000;
    step();
    chk("bp_drain", e_valid, 0);

    // Select pointing at an idle channel stalls everyone.
    select   = 2'd0;
    in_valid = 4'b1000;
    #1;
    chk("idle_sel_ready", e_ready, 4'b0001);
    step();
    chk("idle_sel_valid", e_valid, 0);

    // Packet lock on channel 1 with select moving to 3 and a bubble.
    select   = 2'd1;
    in_valid = 4'b1010;
    in_last  = 4'b1000;
    set_data(1, 8'h11);
    set_data(3, 8'h77);
    step();
    chk("lk_d0", e_data, 8'h11);
    chk("lk_c0", e_chan, 1);
    chk("lk_l0", e_last, 0);
    chk("lk_lock0", e_locked, 1);
    select = 2'd3;
    set_data(1, 8'h22);
    step();
    chk("lk_d1", e_data, 8'h22);
    chk("lk_c1", e_chan, 1);
    chk("lk_lock1", e_locked, 1);
    in_valid = 4'b1000;
    #1;
    chk("lk_bub_ready", e_ready, 4'b0010);
    step();
    chk("lk_bub_valid", e_valid, 0);
    chk("lk_bub_lock", e_locked, 1);
    in_valid = 4'b1010;
    in_last  = 4'b1010;
    set_data(1, 8'h33);
    step();
    chk("lk_d2", e_data, 8'h33);
    chk("lk_c2", e_chan, 1);
    chk("lk_l2", e_last, 1);
    chk("lk_unlock", e_locked, 0);
    #1;
    chk("lk_ch3_ready", e_ready, 4'b1000);
    step();
    chk("lk_ch3_data", e_data, 8'h77);
    chk("lk_ch3_chan", e_chan, 3);

    // Reset mid-packet drops lock and the in-flight beat.
    select   = 2'd1;
    in_valid = 4'b0010;
    in_last  = 4'b0000;
    set_data(1, 8'h44);
    step();
    chk("mr_pre_lock", e_locked, 1);
    chk("mr_pre_data", e_data, 8'h44);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", e_valid, 0);
    chk("mr_lock", e_locked, 0);
    chk("mr_data", e_data, 0);
    in_valid = 4'b0000;
    select   = 2'd2;
    step();
    rst_n = 1'b1;
    #1;
    chk("mr_e_ready", e_ready, 4'b0100);
    chk("mr_r_ready", r_ready, 4'b0000);

    // MODE 1 fairness, 1-beat packets: 0,1,2,3,0,1 from reset.
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    for (int k = 0; k < 4; k++) set_data(k, 8'hD0 + 8'(k));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr1_chan", r_chan, i % 4);
      chk("rr1_data", r_data, 8'hD0 + (i % 4));
      chk("rr1_valid", r_valid, 1);
    end
    // 2-beat packets continue after channel 1: 2,2,3,3,0,0,1,1.
    for (int p = 0; p < 4; p++) begin
      in_last = 4'b0000;
      step();
      chk("rr2_chan_a", r_chan, (2 + p) % 4);
      chk("rr2_last_a", r_last, 0);
      chk("rr2_lock_a", r_locked, 1);
      in_last = 4'b1111;
      step();
      chk("rr2_chan_b", r_chan, (2 + p) % 4);
      chk("rr2_last_b", r_last, 1);
      chk("rr2_lock_b", r_locked, 0);
    end

    // Skip/wrap: only channels 0 and 3, pointer at 3 after reset.
    rst_n = 1'b0;
    in_valid = 4'b1001;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap_chan", r_chan, (i % 2 == 0) ? 0 : 3);
      chk("wrap_valid", r_valid, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised successor to the combinational select mux.
- Merges 2^SELECT_WIDTH valid/ready input streams onto one registered output stream.
- Channel choice comes from an external select (MODE 0) or a round-robin arbiter (MODE 1).
- Multi-beat packets, delimited by in_last, are locked to one channel until their last beat. Used between CPU-side producers (bus masters, debug/UART sources) and a single consumer.

Parameters:
- DATA_WIDTH, 8, payload width per channel.
- SELECT_WIDTH, 2, channel index width; CHANNELS = 1 << SELECT_WIDTH.
- ARB_MODE, 0, 0 = external select, 1 = round-robin.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_datas  input  DATA_WIDTH*CHANNELS  packed payloads; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  CHANNELS  per-channel beat valid.
- in_last  input  CHANNELS  per-channel last-beat-of-packet flag.
- in_ready  output  CHANNELS  per-channel accept, combinational.
- select  input  SELECT_WIDTH  requested channel; ignored when ARB_MODE=1.
- out_data  output  DATA_WIDTH  registered payload.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last flag.
- out_channel  output  SELECT_WIDTH  source channel of the current out beat.
- out_ready  input  1  downstream accept.
- locked  output  1  high while a packet is in progress, i.e. after a non-last beat has been accepted.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_channel=0, locked=0, lock_chan=0, rr_ptr=CHANNELS-1. in_ready follows from these values.
- load_en = !out_valid || out_ready. This is a single output register with 1-cycle latency, full throughput and no skid buffer.
- Grant selection, combinational, evaluated in priority order:
  1. If locked: grant = lock_chan.
  2. Else if ARB_MODE=0: grant = select.
  3. Else: grant = first k with in_valid[k] set, scanning (rr_ptr+1) mod CHANNELS upward with wrap. If none is valid, there is no grant.
- in_ready[k] = load_en && grant valid && k == grant. All other bits are 0.
- Transfer on channel g when in_valid[g] && in_ready[g]. On that clock edge: out_data <= in_datas[g], out_last <= in_last[g], out_channel <= g, out_valid <= 1.
- Lock FSM, two states:
  - IDLE -> LOCKED on a transfer with in_last=0; lock_chan <= g.
  - LOCKED -> IDLE on a transfer with in_last=1.
  - LOCKED persists through bubbles: if in_valid[lock_chan]=0, no other channel is served and select changes are ignored.
  - A single-beat packet (in_last=1 while IDLE) stays in IDLE.
- RR pointer: rr_ptr <= g only on a transfer with in_last=1. The pointer advances per packet, not per beat.
- With no transfer: if out_valid && out_ready then out_valid <= 0. Otherwise the output holds, and out_data/out_last/out_channel stay stable while out_valid=1 && out_ready=0.
- Simultaneous drain and load in one cycle: the new beat replaces the old; out_valid stays 1.
- ARB_MODE=0 with select pointing at an idle channel: no transfer, other channels stall.
- Reset mid-packet: the lock is dropped and the in-flight output beat is discarded. The upstream must restart the packet.
- CHANNELS=2 (SELECT_WIDTH=1) and wide DATA_WIDTH must synthesise without change. No division or modulo hardware: wrap comes from the natural SELECT_WIDTH overflow.

Test Plan:
- Reset/idle: rst_n=0 mid-run, then release with all in_valid=0 -> out_valid=0, locked=0, in_ready=0 in MODE 1, in_ready[select]=1 in MODE 0.
- MODE 0 single beats: select=2, in_valid=4'b0100, data ch2=0xA5, last=1, out_ready=1 -> next cycle out_data=0xA5, out_channel=2, out_last=1; one beat per cycle when held.
- Backpressure: out_ready=0 for 3 cycles with valid beat 0x3C held -> out_* stable, in_ready=0; out_ready=1 -> beat consumed, next beat loaded in the same cycle.
- Packet lock: MODE 0, ch1 sends 0x11,0x22,0x33 (last on 0x33), select switched to 3 after the first beat, ch1 bubbles one cycle -> output is 0x11,0x22,0x33 from ch1 only, locked=1 until 0x33 accepted, then ch3 served.
- Round-robin fairness: MODE 1, all four channels valid continuously with 1-beat packets -> out_channel sequence 0,1,2,3,0,1… from reset; with 2-beat packets, each channel delivers both beats before rotation.
- RR skip/wrap: MODE 1, only ch3 and ch0 valid, rr_ptr=3 -> ch0 served, then ch3, then ch0; no cycles lost on invalid channels.
